// File: rtl/exp_table_reducer.sv
// Captures an (address, data) write stream into a 512x18 table and, on start,
// sweeps the first iLen entries to report their sum, maximum and max address.
module exp_table_reducer #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int SUM_W  = 27
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iWrEn,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [DATA_W-1:0] iData,
    input  logic              iStart,
    input  logic [ADDR_W:0]   iLen,
    output logic [SUM_W-1:0]  oSum,
    output logic [DATA_W-1:0] oMax,
    output logic [ADDR_W-1:0] oMaxAddr,
    output logic              oBusy,
    output logic              oDone
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clamped;
    logic [SUM_W-1:0]  acc_sum;
    logic [DATA_W-1:0] acc_max;
    logic [ADDR_W-1:0] acc_addr;

    assign len_clamped = (iLen > MAX_LEN) ? MAX_LEN : iLen;

    // Table RAM: not reset, frozen outside IDLE, one-cycle registered read.
    always_ff @(posedge CLK) begin
        if (state == IDLE && iWrEn) begin
            mem[iAddr] <= iData;
        end
        rd_data <= mem[rd_cnt];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
            len      <= '0;
            acc_sum  <= '0;
            acc_max  <= '0;
            acc_addr <= '0;
            oSum     <= '0;
            oMax     <= '0;
            oMaxAddr <= '0;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
        end else begin
            oDone    <= 1'b0;
            rd_valid <= (state == READ);
            rd_addr  <= rd_cnt;

            // Strict compare on an ascending sweep keeps the lowest address on ties.
            if (rd_valid) begin
                acc_sum <= acc_sum + SUM_W'(rd_data);
                if (rd_data > acc_max) begin
                    acc_max  <= rd_data;
                    acc_addr <= rd_addr;
                end
            end

            case (state)
                IDLE: begin
                    oBusy <= 1'b0;
                    if (iStart) begin
                        oBusy    <= 1'b1;
                        acc_sum  <= '0;
                        acc_max  <= '0;
                        acc_addr <= '0;
                        rd_cnt   <= '0;
                        len      <= len_clamped;
                        state    <= (len_clamped == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if ({1'b0, rd_cnt} == len - 1'b1) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= DONE;
                end
                DONE: begin
                    oSum     <= acc_sum;
                    oMax     <= acc_max;
                    oMaxAddr <= acc_addr;
                    oDone    <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_table_reducer.sv
// Directed bench for exp_table_reducer with hand-computed expectations.
module tb_exp_table_reducer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iWrEn = 1'b0;
    logic [8:0]  iAddr = '0;
    logic [17:0] iData = '0;
    logic        iStart = 1'b0;
    logic [9:0]  iLen = '0;
    logic [26:0] oSum;
    logic [17:0] oMax;
    logic [8:0]  oMaxAddr;
    logic        oBusy;
    logic        oDone;

    int checks   = 0;
    int failures = 0;
    int lat;
    longint model_sum;
    int model_max;
    int model_addr;
    int value;

    exp_table_reducer dut (
        .CLK(CLK), .RST(RST), .iWrEn(iWrEn), .iAddr(iAddr), .iData(iData),
        .iStart(iStart), .iLen(iLen), .oSum(oSum), .oMax(oMax),
        .oMaxAddr(oMaxAddr), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called and returns just after a rising edge.
    task automatic applyStimulus(input int addr, input int data);
        iWrEn = 1'b1;
        iAddr = 9'(addr);
        iData = 18'(data);
        @(posedge CLK); #1;
        iWrEn = 1'b0;
    endtask

    task automatic runSweep(input int len, input logic wr, input int wr_addr, input int wr_data,
                            input logic disturb, output int latency);
        bit found = 0;
        iStart = 1'b1;
        iLen   = 10'(len);
        iWrEn  = wr;
        iAddr  = 9'(wr_addr);
        iData  = 18'(wr_data);
        @(posedge CLK); #1;
        iStart = 1'b0;
        iWrEn  = 1'b0;
        latency = -1;
        checkOutput("busy_after_start", 64'(oBusy), 64'd1);
        for (int c = 1; c <= len + 20 && !found; c++) begin
            @(posedge CLK); #1;
            if (oDone) begin
                latency = c;
                found = 1;
            end else if (disturb && c == 2) begin
                iWrEn = 1'b1; iAddr = 9'd2; iData = 18'd999;
                iStart = 1'b1; iLen = 10'd4;
            end else if (disturb && c == 3) begin
                iWrEn = 1'b0; iStart = 1'b0;
            end
        end
        iWrEn = 1'b0; iStart = 1'b0;
        if (!found) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("busy_in_done_cycle", 64'(oBusy), 64'd1);
        end
    endtask

    task automatic checkAfterDone(input string tag, input logic [63:0] sum, input int mx, input int mx_addr);
        checkOutput({tag, "_sum"}, 64'(oSum), sum);
        checkOutput({tag, "_max"}, 64'(oMax), 64'(mx));
        checkOutput({tag, "_maxaddr"}, 64'(oMaxAddr), 64'(mx_addr));
        @(posedge CLK); #1;
        checkOutput({tag, "_done_width"}, 64'(oDone), 64'd0);
        checkOutput({tag, "_busy_low"}, 64'(oBusy), 64'd0);
        checkOutput({tag, "_sum_hold"}, 64'(oSum), sum);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_sum", 64'(oSum), 64'd0);
        checkOutput("rst_max", 64'(oMax), 64'd0);
        checkOutput("rst_maxaddr", 64'(oMaxAddr), 64'd0);
        checkOutput("rst_busy", 64'(oBusy), 64'd0);
        checkOutput("rst_done", 64'(oDone), 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        $display("[TB] partial table with tie");
        applyStimulus(0, 100);
        applyStimulus(1, 300);
        applyStimulus(2, 300);
        applyStimulus(3, 50);
        runSweep(4, 1'b0, 0, 0, 1'b0, lat);
        checkOutput("tie_latency", 64'(lat), 64'd6);
        checkAfterDone("tie", 64'd750, 300, 1);

        $display("[TB] zero length");
        runSweep(0, 1'b0, 0, 0, 1'b0, lat);
        checkOutput("zero_latency", 64'(lat), 64'd1);
        checkAfterDone("zero", 64'd0, 0, 0);

        $display("[TB] write and start ignored during sweep");
        applyStimulus(4, 10);
        applyStimulus(5, 20);
        applyStimulus(6, 30);
        applyStimulus(7, 40);
        runSweep(8, 1'b0, 0, 0, 1'b1, lat);
        checkOutput("ign_latency", 64'(lat), 64'd10);
        checkAfterDone("ign", 64'd850, 300, 1);
        runSweep(4, 1'b0, 0, 0, 1'b0, lat);
        checkAfterDone("ign_frozen", 64'd750, 300, 1);

        $display("[TB] ramp fill");
        for (int a = 0; a < 512; a++) applyStimulus(a, a);
        runSweep(512, 1'b0, 0, 0, 1'b0, lat);
        checkOutput("ramp_latency", 64'(lat), 64'd514);
        checkAfterDone("ramp", 64'd130816, 511, 511);
        runSweep(1023, 1'b0, 0, 0, 1'b0, lat);
        checkOutput("clamp_latency", 64'(lat), 64'd514);
        checkAfterDone("clamp", 64'd130816, 511, 511);

        $display("[TB] saturated table");
        for (int a = 0; a < 512; a++) applyStimulus(a, 262143);
        runSweep(512, 1'b0, 0, 0, 1'b0, lat);
        checkAfterDone("sat", 64'd134217216, 262143, 0);

        $display("[TB] reset mid-sweep");
        applyStimulus(0, 5);
        applyStimulus(1, 6);
        applyStimulus(2, 7);
        applyStimulus(3, 8);
        iStart = 1'b1; iLen = 10'd512;
        @(posedge CLK); #1;
        iStart = 1'b0;
        repeat (100) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(oBusy), 64'd0);
        checkOutput("midrst_done", 64'(oDone), 64'd0);
        checkOutput("midrst_sum", 64'(oSum), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        checkOutput("midrst_no_done", 64'(oDone), 64'd0);
        runSweep(4, 1'b0, 0, 0, 1'b0, lat);
        checkOutput("post_rst_latency", 64'(lat), 64'd6);
        checkAfterDone("post_rst", 64'd26, 8, 3);

        $display("[TB] streamed table, last write with start");
        model_sum = 0; model_max = 0; model_addr = 0;
        for (int a = 0; a < 512; a++) begin
            value = (a % 97 == 13) ? 262000 : int'($urandom_range(0, 200000));
            model_sum += value;
            if (value > model_max) begin
                model_max = value;
                model_addr = a;
            end
            if (a < 511) applyStimulus(a, value);
        end
        runSweep(512, 1'b1, 511, value, 1'b0, lat);
        checkOutput("stream_latency", 64'(lat), 64'd514);
        checkAfterDone("stream", 64'(model_sum), model_max, model_addr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exp_table_reducer.md
# exp_table_reducer

Downstream consumer of the exp-table generator (`CalculateExpMu`). It captures the generator's `(address, data)` write stream into an internal 512×18 RAM. When started, it sweeps the first `iLen` entries and reports their sum, the maximum value and the address of the maximum. The risk-calculation datapath uses these results for normalisation.

## Interface
Parameters:
- DATA_W, 18, width of table entries (unsigned fixed point, same format as the generator's oData)
- ADDR_W, 9, table address width
- DEPTH, 512, table depth (2^ADDR_W)
- SUM_W, 27, accumulator width (DATA_W + ADDR_W; cannot overflow)

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- iWrEn  in  1  write strobe for iAddr/iData
- iAddr  in  ADDR_W  write address (connects to generator oAddr)
- iData  in  DATA_W  write data (connects to generator oData)
- iStart  in  1  start reduction (connects to generator oDone); sampled on the rising edge
- iLen  in  ADDR_W+1  number of entries to reduce, 0..512
- oSum  out  SUM_W  sum of entries 0..iLen-1
- oMax  out  DATA_W  largest entry
- oMaxAddr  out  ADDR_W  address of largest entry
- oBusy  out  1  high while reduction runs
- oDone  out  1  one-cycle pulse when results are valid

## Operation
- RAM: 512×18, one synchronous write port and one synchronous read port with 1-cycle read latency. RST does not clear the RAM.
- Writes:
  - Committed when iWrEn=1 and the block is in IDLE.
  - Dropped when the block is in READ or DRAIN; the table is frozen during a sweep.
- States:
  - IDLE: oBusy=0. On iStart=1:
    - If captured length is 0: go to DONE, with results oSum=0, oMax=0, oMaxAddr=0.
    - Otherwise: capture iLen, clear internal accumulators, read address counter=0, go to READ.
  - READ: issue read address rd_cnt each cycle, rd_cnt+1. When rd_cnt == len-1 has been issued, go to DRAIN.
  - DRAIN: accumulate the last read word, go to DONE.
  - DONE: copy internal accumulators to oSum/oMax/oMaxAddr, pulse oDone, go to IDLE.
- Accumulation: each returned word d at address a:
  - sum += d (zero-extended to SUM_W).
  - If d > max (strict), then max = d and maxaddr = a.
  - Ties keep the lowest address. An all-zero table gives oMax=0, oMaxAddr=0.
- Result stability: oSum/oMax/oMaxAddr change only in DONE and hold until the next DONE.
- iStart is ignored when not in IDLE.
- iLen is sampled only on an accepted iStart. Values >512 are clamped to 512.
- Write and start in the same cycle (IDLE): the write commits on that edge and is visible to the sweep.

## Timing
- Reset values: oSum=0, oMax=0, oMaxAddr=0, oBusy=0, oDone=0, state=IDLE.
- For an iStart accepted at edge 0 with length N≥1:
  - Read addresses are issued at edges 1..N.
  - Data is accumulated at edges 2..N+1.
  - Results and oDone=1 appear after edge N+2.
  - Total latency from iStart to oDone is N+2 cycles.
- For N=0: oDone is high after edge 1.
- oBusy is high from after edge 0 through the DONE cycle inclusive, and is low on the cycle after the oDone pulse.
- oDone width is exactly one cycle.
- The earliest new iStart is accepted on the cycle after oDone.
- RST asserted mid-sweep:
  - Immediately forces IDLE, outputs to their reset values, no oDone.
  - RAM contents are retained.
- Throughput: one entry per cycle, no stalls.

## Test plan
- Reset: assert RST mid-READ with N=512 -> oBusy=0, oDone=0 and oSum=0 at once. After release, with writes since reset dropped, a new start of N=4 sums the previously written entries.
- Ramp fill: write data=addr for addr 0..511, then iStart with iLen=512 -> oDone 514 cycles after iStart, oSum=130816, oMax=511, oMaxAddr=511.
- Partial and tie: entries 0..3 = 100, 300, 300, 50, iLen=4 -> oSum=750, oMax=300, oMaxAddr=1, oDone 6 cycles after iStart.
- Saturation bound: all 512 entries = 0x3FFFF, iLen=512 -> oSum=134217216, no wrap, oMax=262143, oMaxAddr=0.
- Zero length and ignored inputs: iLen=0 -> oDone 1 cycle after iStart, all results 0. During an N=8 sweep, iWrEn to addr 2 with 999 and a second iStart -> both ignored, and the results match the pre-sweep table.
- Back-to-back with the generator: drive the generator's stream (iMu=184, iS=24576) into iWrEn/iAddr/iData, and its oDone into iStart, with iLen=512 -> oSum and oMax equal a software reduction of the captured stream.
